// File: rtl/sprite_frame_scanner.sv
// Sprite frame scanner: sweeps every pixel address of a 128x128 1-bpp screen
// through one Sprite, writes the composed pixel into a framebuffer with
// ready back-pressure, then steps the sprite position (bounce or wrap).
//
// state | meaning
// IDLE  | waiting for frame_start
// SCAN  | issuing addresses 0..16383, one pipeline load per accepted slot
// FLUSH | last write pending, waiting for fb_ready
// MOVE  | frame_done pulse, position update applied on exit
module sprite_frame_scanner #(
  parameter logic [6:0] SPR_WIDTH  = 7'd32,
  parameter logic [6:0] SPR_HEIGHT = 7'd32,
  parameter logic [6:0] X_INIT     = 7'd0,
  parameter logic [6:0] Y_INIT     = 7'd0,
  parameter logic       BG_PIXEL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic [13:0] spr_addr,
  output logic [6:0]  spr_xpos,
  output logic [6:0]  spr_ypos,
  input  logic        spr_non_sprite,
  input  logic        spr_pixel,
  input  logic        spr_collidable,
  input  logic        fb_ready,
  output logic        fb_we,
  output logic [13:0] fb_waddr,
  output logic        fb_wdata,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, MOVE} state_t;

  state_t      state_q;
  logic [13:0] spr_addr_q;
  logic [6:0]  xpos_q, ypos_q;
  logic        dx_neg_q, dy_neg_q;
  logic        fb_we_q;
  logic [13:0] fb_waddr_q;
  logic        fb_wdata_q;
  logic        busy_q;
  logic        frame_done_q;

  logic [6:0]  xpos_d, ypos_d;
  logic        dx_neg_d, dy_neg_d;
  logic        slot_free;

  // One axis of motion: bounce off the borders when collidable, otherwise
  // move by one with 7-bit wrap. Result is {direction_negative, new_pos}.
  function automatic logic [7:0] axis_step(input logic [6:0] pos,
                                           input logic       neg,
                                           input logic [6:0] size,
                                           input logic       coll);
    logic [7:0] far_edge;
    logic [7:0] res;
    far_edge = {1'b0, pos} + {1'b0, size};
    if (coll && !neg && far_edge == 8'd128)
      res = {1'b1, pos - 7'd1};
    else if (coll && neg && pos == 7'd0)
      res = {1'b0, pos + 7'd1};
    else if (neg)
      res = {1'b1, pos - 7'd1};
    else
      res = {1'b0, pos + 7'd1};
    return res;
  endfunction

  // The output slot can take a new pixel when empty or being drained this cycle.
  assign slot_free = !fb_we_q || fb_ready;

  // Candidate next position; only committed when leaving MOVE.
  assign {dx_neg_d, xpos_d} = axis_step(xpos_q, dx_neg_q, SPR_WIDTH,  spr_collidable);
  assign {dy_neg_d, ypos_d} = axis_step(ypos_q, dy_neg_q, SPR_HEIGHT, spr_collidable);

  // Frame sequencer, address sweep, write pipeline and position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      spr_addr_q   <= 14'd0;
      xpos_q       <= X_INIT;
      ypos_q       <= Y_INIT;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= 14'd0;
      fb_wdata_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q    <= SCAN;
            spr_addr_q <= 14'd0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (slot_free) begin
            fb_we_q    <= 1'b1;
            fb_waddr_q <= spr_addr_q;
            fb_wdata_q <= spr_non_sprite ? BG_PIXEL : spr_pixel;
            // Natural 14-bit wrap leaves the address at 0 after the last pixel.
            spr_addr_q <= spr_addr_q + 14'd1;
            if (spr_addr_q == 14'h3FFF)
              state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (fb_ready) begin
            fb_we_q      <= 1'b0;
            state_q      <= MOVE;
            frame_done_q <= 1'b1;
          end
        end
        MOVE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          xpos_q   <= xpos_d;
          dx_neg_q <= dx_neg_d;
          ypos_q   <= ypos_d;
          dy_neg_q <= dy_neg_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spr_addr   = spr_addr_q;
  assign spr_xpos   = xpos_q;
  assign spr_ypos   = ypos_q;
  assign fb_we      = fb_we_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_wdata   = fb_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_frame_scanner.sv
// Bench for sprite_frame_scanner: a main instance with a sprite model for
// write-stream checks, plus two free-running instances for bounce and wrap.
module tb_sprite_frame_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // main instance (sprite at 10,10, 32x32, not collidable)
  logic        frame_start, fb_ready;
  logic [13:0] spr_addr, fb_waddr;
  logic [6:0]  spr_xpos, spr_ypos;
  logic        spr_non_sprite, spr_pixel, fb_we, fb_wdata, busy, frame_done;
  logic        m_collidable;

  // bounce instance (collidable) and wrap instance (not collidable)
  logic        mot_start;
  logic [13:0] b_addr, b_waddr, w_addr, w_waddr;
  logic [6:0]  b_xpos, b_ypos, w_xpos, w_ypos;
  logic        b_we, b_wdata, b_busy, b_done;
  logic        w_we, w_wdata, w_busy, w_done;

  sprite_frame_scanner #(.SPR_WIDTH(7'd32), .SPR_HEIGHT(7'd32), .X_INIT(7'd10),
                         .Y_INIT(7'd10), .BG_PIXEL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .spr_addr(spr_addr),
    .spr_xpos(spr_xpos), .spr_ypos(spr_ypos), .spr_non_sprite(spr_non_sprite),
    .spr_pixel(spr_pixel), .spr_collidable(m_collidable), .fb_ready(fb_ready),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .busy(busy),
    .frame_done(frame_done));

  sprite_frame_scanner #(.SPR_WIDTH(7'd32), .SPR_HEIGHT(7'd127), .X_INIT(7'd95),
                         .Y_INIT(7'd0), .BG_PIXEL(1'b0)) u_bnc (
    .clk(clk), .reset(reset), .frame_start(mot_start), .spr_addr(b_addr),
    .spr_xpos(b_xpos), .spr_ypos(b_ypos), .spr_non_sprite(1'b1),
    .spr_pixel(1'b0), .spr_collidable(1'b1), .fb_ready(1'b1),
    .fb_we(b_we), .fb_waddr(b_waddr), .fb_wdata(b_wdata), .busy(b_busy),
    .frame_done(b_done));

  sprite_frame_scanner #(.SPR_WIDTH(7'd32), .SPR_HEIGHT(7'd32), .X_INIT(7'd127),
                         .Y_INIT(7'd127), .BG_PIXEL(1'b0)) u_wrp (
    .clk(clk), .reset(reset), .frame_start(mot_start), .spr_addr(w_addr),
    .spr_xpos(w_xpos), .spr_ypos(w_ypos), .spr_non_sprite(1'b1),
    .spr_pixel(1'b0), .spr_collidable(1'b0), .fb_ready(1'b1),
    .fb_we(w_we), .fb_waddr(w_waddr), .fb_wdata(w_wdata), .busy(w_busy),
    .frame_done(w_done));

  // Sprite model for the main instance: 32x32 box at the DUT's position,
  // pixel pattern derived from the screen address.
  assign spr_non_sprite = !((spr_addr[6:0] >= spr_xpos) &&
                            ({1'b0, spr_addr[6:0]} < ({1'b0, spr_xpos} + 8'd32)) &&
                            (spr_addr[13:7] >= spr_ypos) &&
                            ({1'b0, spr_addr[13:7]} < ({1'b0, spr_ypos} + 8'd32)));
  assign spr_pixel = spr_addr[0] ^ spr_addr[8];

  // Expected framebuffer data for address a with the sprite at (x,y).
  function automatic logic exp_pix(input int a, input int x, input int y);
    int c, r;
    c = a % 128;
    r = a / 128;
    if (c >= x && c < x + 32 && r >= y && r < y + 32) return logic'(a[0] ^ a[8]);
    return 1'b0;
  endfunction

  // Position history of the motion instances, captured just after MOVE exit.
  logic [6:0] bnc_x [0:3];
  logic [6:0] bnc_y [0:3];
  logic [6:0] wrp_x [0:3];
  logic [6:0] wrp_y [0:3];
  int   n_bnc = 0, n_wrp = 0;
  logic b_done_d = 1'b0, w_done_d = 1'b0;

  always @(negedge clk) begin
    if (b_done_d && !b_done && n_bnc < 4) begin
      bnc_x[n_bnc] = b_xpos;
      bnc_y[n_bnc] = b_ypos;
      n_bnc++;
    end
    if (w_done_d && !w_done && n_wrp < 4) begin
      wrp_x[n_wrp] = w_xpos;
      wrp_y[n_wrp] = w_ypos;
      n_wrp++;
    end
    b_done_d = b_done;
    w_done_d = w_done;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || spr_addr !== 14'd0 ||
        fb_waddr !== 14'd0 || fb_wdata !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b busy=%b done=%b addr=%0d waddr=%0d wdata=%b, required all 0",
               fb_we, busy, frame_done, spr_addr, fb_waddr, fb_wdata);
    end
    checks++;
    if (spr_xpos !== 7'd10 || spr_ypos !== 7'd10) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d), required (10,10)", spr_xpos, spr_ypos);
    end
    checks++;
    if (b_xpos !== 7'd95 || b_ypos !== 7'd0 || w_xpos !== 7'd127 || w_ypos !== 7'd127) begin
      errors++;
      $display("FAIL reset_pos_motion: bnc (%0d,%0d) wrp (%0d,%0d), required (95,0) (127,127)",
               b_xpos, b_ypos, w_xpos, w_ypos);
    end
    reset = 1'b0;
    mot_start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start: busy=%b we=%b, required 0 0", busy, fb_we);
    end
  endtask

  // Full frame with fb_ready=1 and frame_start held high throughout.
  task automatic test_frame_hold_start();
    int n, n_wr, n_bad, first_bad, done_at, done_cnt;
    n = 0; n_wr = 0; n_bad = 0; first_bad = -1; done_at = -1; done_cnt = 0;
    fb_ready = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_accept: busy=%b, required 1", busy);
    end
    while (n < 16387) begin
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        if (fb_waddr !== 14'(n_wr) || fb_wdata !== exp_pix(n_wr, 10, 10)) begin
          n_bad++;
          if (first_bad < 0) first_bad = n_wr;
        end
        n_wr++;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == 1) begin
        checks++;
        if (fb_we !== 1'b1 || fb_waddr !== 14'd0) begin
          errors++;
          $display("FAIL first_write: we=%b waddr=%0d, required 1 0", fb_we, fb_waddr);
        end
      end
      if (n == 16384) begin
        checks++;
        if (fb_we !== 1'b1 || fb_waddr !== 14'h3FFF || spr_addr !== 14'd0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL last_write: we=%b waddr=%0d addr=%0d done=%b, required 1 16383 0 0",
                   fb_we, fb_waddr, spr_addr, frame_done);
        end
      end
      if (n == 16385) begin
        checks++;
        if (fb_we !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL move_state: we=%b busy=%b, required 0 1", fb_we, busy);
        end
      end
      if (n == 16386) begin
        checks++;
        if (busy !== 1'b0 || spr_xpos !== 7'd11 || spr_ypos !== 7'd11) begin
          errors++;
          $display("FAIL idle_new_pos: busy=%b pos=(%0d,%0d), required 0 (11,11)",
                   busy, spr_xpos, spr_ypos);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_idle: busy=%b, required 1", busy);
    end
    checks++;
    if (n_wr !== 16384 || n_bad !== 0) begin
      errors++;
      $display("FAIL frame_writes: count=%0d bad=%0d first_bad=%0d, required 16384 0", n_wr, n_bad, first_bad);
    end
    checks++;
    if (done_at !== 16385 || done_cnt !== 1) begin
      errors++;
      $display("FAIL frame_done_timing: edge=k+%0d pulses=%0d, required k+16385 1", done_at, done_cnt);
    end
  endtask

  // Continues the sweep started above with random back-pressure and one long stall.
  task automatic test_backpressure();
    int   n, n_wr, n_bad, first_bad, hold_left, hold_bad;
    logic held_done, seen_done;
    logic [13:0] h_waddr, h_saddr;
    logic h_wdata;
    n = 0; n_wr = 0; n_bad = 0; first_bad = -1; hold_left = 0; hold_bad = 0;
    held_done = 1'b0; seen_done = 1'b0;
    h_waddr = 14'd0; h_saddr = 14'd0; h_wdata = 1'b0;
    frame_start = 1'b0;
    while (n < 80000 && !seen_done) begin
      if (hold_left > 0) begin
        fb_ready = 1'b0;
        if (fb_we !== 1'b1 || fb_waddr !== h_waddr || fb_wdata !== h_wdata || spr_addr !== h_saddr)
          hold_bad++;
        hold_left--;
      end else if (!held_done && fb_we === 1'b1 && fb_waddr === 14'd100) begin
        fb_ready = 1'b0;
        hold_left = 19;
        held_done = 1'b1;
        h_waddr = fb_waddr;
        h_wdata = fb_wdata;
        h_saddr = spr_addr;
      end else begin
        fb_ready = 1'($urandom_range(0, 1));
      end
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        if (fb_waddr !== 14'(n_wr) || fb_wdata !== exp_pix(n_wr, 11, 11)) begin
          n_bad++;
          if (first_bad < 0) first_bad = n_wr;
        end
        n_wr++;
      end
      if (frame_done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
      n++;
    end
    fb_ready = 1'b1;
    checks++;
    if (seen_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: frame_done not seen after %0d cycles", n);
    end
    checks++;
    if (n_wr !== 16384 || n_bad !== 0) begin
      errors++;
      $display("FAIL bp_writes: count=%0d bad=%0d first_bad=%0d, required 16384 0", n_wr, n_bad, first_bad);
    end
    checks++;
    if (held_done !== 1'b1 || hold_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: stall_seen=%b bad_cycles=%0d, required 1 0", held_done, hold_bad);
    end
    checks++;
    if (busy !== 1'b0 || spr_xpos !== 7'd12 || spr_ypos !== 7'd12) begin
      errors++;
      $display("FAIL bp_new_pos: busy=%b pos=(%0d,%0d), required 0 (12,12)", busy, spr_xpos, spr_ypos);
    end
  endtask

  task automatic test_motion();
    int t;
    t = 0;
    while ((n_bnc < 3 || n_wrp < 2) && t < 70000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (n_bnc < 3 || n_wrp < 2) begin
      errors++;
      $display("FAIL motion_timeout: frames bnc=%0d wrp=%0d, required 3 2", n_bnc, n_wrp);
    end
    checks++;
    if (bnc_x[0] !== 7'd96 || bnc_x[1] !== 7'd95 || bnc_x[2] !== 7'd94) begin
      errors++;
      $display("FAIL bounce_x: got %0d,%0d,%0d, required 96,95,94", bnc_x[0], bnc_x[1], bnc_x[2]);
    end
    checks++;
    if (bnc_y[0] !== 7'd1 || bnc_y[1] !== 7'd0 || bnc_y[2] !== 7'd1) begin
      errors++;
      $display("FAIL bounce_y: got %0d,%0d,%0d, required 1,0,1", bnc_y[0], bnc_y[1], bnc_y[2]);
    end
    checks++;
    if (wrp_x[0] !== 7'd0 || wrp_y[0] !== 7'd0) begin
      errors++;
      $display("FAIL wrap_first: got (%0d,%0d), required (0,0)", wrp_x[0], wrp_y[0]);
    end
    checks++;
    if (wrp_x[1] !== 7'd1 || wrp_y[1] !== 7'd1) begin
      errors++;
      $display("FAIL wrap_second: got (%0d,%0d), required (1,1)", wrp_x[1], wrp_y[1]);
    end
  endtask

  task automatic test_reset_mid_scan();
    fb_ready = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fb_we !== 1'b1 || spr_addr < 14'd400) begin
      errors++;
      $display("FAIL mid_scan_reached: busy=%b we=%b addr=%0d, required 1 1 >=400", busy, fb_we, spr_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || spr_addr !== 14'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: we=%b busy=%b addr=%0d done=%b, required 0 0 0 0",
               fb_we, busy, spr_addr, frame_done);
    end
    checks++;
    if (spr_xpos !== 7'd10 || spr_ypos !== 7'd10) begin
      errors++;
      $display("FAIL mid_reset_pos: got (%0d,%0d), required (10,10)", spr_xpos, spr_ypos);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || spr_addr !== 14'd0) begin
      errors++;
      $display("FAIL no_writes_after_reset: we=%b busy=%b addr=%0d, required 0 0 0", fb_we, busy, spr_addr);
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    fb_ready = 1'b1;
    mot_start = 1'b0;
    m_collidable = 1'b0;
    test_reset();
    test_frame_hold_start();
    test_backpressure();
    test_motion();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
